// File: rtl/legv8_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 control unit.
package legv8_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    typedef enum logic [2:0] {
        CL_R,
        CL_D_LD,
        CL_D_ST,
        CL_B,
        CL_CBZ,
        CL_CBNZ,
        CL_IW,
        CL_ILL
    } instr_class_e;

    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [8:0]  OP_MOVK = 9'b111100101;

    localparam logic [3:0] ALU_AND    = 4'b0001;
    localparam logic [3:0] ALU_ORR    = 4'b0010;
    localparam logic [3:0] ALU_PASS_B = 4'b0101;
    localparam logic [3:0] ALU_ADD    = 4'b0110;
    localparam logic [3:0] ALU_SUB    = 4'b0111;
    localparam logic [3:0] ALU_MOVK   = 4'b1000;
    localparam logic [3:0] ALU_NONE   = 4'b0000;

    // op is IR[31:21]; the shorter opcode fields are its leading bits.
    function automatic instr_class_e classify(input logic [10:0] op);
        instr_class_e c;
        c = CL_ILL;
        if (op == OP_AND || op == OP_ADD || op == OP_ORR || op == OP_SUB)
            c = CL_R;
        else if (op == OP_LDUR)
            c = CL_D_LD;
        else if (op == OP_STUR)
            c = CL_D_ST;
        else if (op[10:5] == OP_B)
            c = CL_B;
        else if (op[10:3] == OP_CBZ)
            c = CL_CBZ;
        else if (op[10:3] == OP_CBNZ)
            c = CL_CBNZ;
        else if (op[10:2] == OP_MOVK)
            c = CL_IW;
        return c;
    endfunction

    function automatic logic [3:0] alu_code(input instr_class_e c, input logic [10:0] op);
        logic [3:0] a;
        a = ALU_NONE;
        case (c)
            CL_R: begin
                if (op == OP_AND)      a = ALU_AND;
                else if (op == OP_ORR) a = ALU_ORR;
                else if (op == OP_SUB) a = ALU_SUB;
                else                   a = ALU_ADD;
            end
            CL_D_LD, CL_D_ST: a = ALU_ADD;
            CL_CBZ, CL_CBNZ:  a = ALU_PASS_B;
            CL_IW:            a = ALU_MOVK;
            default:          a = ALU_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/legv8_imm_ext.sv
// Immediate extender: maps the instruction class and low IR field to the
// DATA_W-wide Extended word (sign-extended offsets, shifted MOVK halfword).
module legv8_imm_ext
    import legv8_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  instr_class_e      cls,
    input  logic [25:0]       imm_field,
    output logic [DATA_W-1:0] extended
);

    logic [DATA_W-1:0] imm16_z;

    assign imm16_z = {{(DATA_W-16){1'b0}}, imm_field[20:5]};

    always_comb begin
        extended = '0;
        case (cls)
            CL_B:             extended = {{(DATA_W-26){imm_field[25]}}, imm_field[25:0]};
            CL_CBZ, CL_CBNZ:  extended = {{(DATA_W-19){imm_field[23]}}, imm_field[23:5]};
            CL_D_LD, CL_D_ST: extended = {{(DATA_W-9){imm_field[20]}}, imm_field[20:12]};
            CL_IW:            extended = imm16_z << {imm_field[22:21], 4'b0000};
            default:          extended = '0;
        endcase
    end

endmodule

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define LEGV8_MC_MEM_TIMEOUT_EN to abort MEM after MEM_TIMEOUT cycles without mem_ack.
module legv8_mc_control
    import legv8_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int REG_AW      = 5,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    input  logic                alu_zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                memread,
    output logic                memwrite,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                alusrc_mux,
    output logic                pc_write,
    output logic                pc_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [REG_AW-1:0]   ReadSelect1,
    output logic [REG_AW-1:0]   ReadSelect2,
    output logic [REG_AW-1:0]   WriteSelect,
    output logic [DATA_W-1:0]   Extended,
    output logic                illegal,
    output logic                busy
);

    state_e            state;
    state_e            state_nxt;
    logic [31:0]       ir;
    instr_class_e      cls;
    logic [3:0]        alu_code_w;
    logic [DATA_W-1:0] ext;
    logic              is_ld;
    logic              is_st;
    logic              uses_imm;
    logic              take_branch;
    logic              mem_to;

    assign cls         = classify(ir[31:21]);
    assign alu_code_w  = alu_code(cls, ir[31:21]);
    assign is_ld       = (cls == CL_D_LD);
    assign is_st       = (cls == CL_D_ST);
    assign uses_imm    = is_ld || is_st || (cls == CL_IW);
    assign take_branch = (cls == CL_B) || ((cls == CL_CBZ) && alu_zero) ||
                         ((cls == CL_CBNZ) && !alu_zero);

    legv8_imm_ext #(
        .DATA_W(DATA_W)
    ) u_imm_ext (
        .cls      (cls),
        .imm_field(ir[25:0]),
        .extended (ext)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= FETCH;
        else
            state <= state_nxt;
    end

    // IR is cleared on reset so selects and Extended come up as zero.
    always_ff @(posedge clk) begin
        if (reset)
            ir <= '0;
        else if (state == FETCH && instr_valid)
            ir <= instr;
    end

`ifdef LEGV8_MC_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    logic [TO_W-1:0] mem_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != MEM)
            mem_cnt <= '0;
        else if (!mem_to)
            mem_cnt <= mem_cnt + 1'b1;
    end

    // Timeout cycle follows MEM_TIMEOUT request cycles; mem_req is dropped in it.
    assign mem_to = (state == MEM) && (mem_cnt == TO_W'(MEM_TIMEOUT));
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;

    assign mem_to = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (instr_valid) state_nxt = DECODE;
            DECODE: state_nxt = (cls == CL_ILL) ? FETCH : EXEC;
            EXEC: begin
                case (cls)
                    CL_D_LD, CL_D_ST: state_nxt = MEM;
                    CL_R, CL_IW:      state_nxt = WB;
                    default:          state_nxt = FETCH;
                endcase
            end
            MEM: begin
                if (mem_to)
                    state_nxt = FETCH;
                else if (mem_ack)
                    state_nxt = is_ld ? WB : FETCH;
            end
            WB:      state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Every output is forced low while reset is asserted, including instr_ready.
    always_comb begin
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        mem2reg     = 1'b0;
        regwrite    = 1'b0;
        alusrc_mux  = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_op      = '0;
        ReadSelect1 = '0;
        ReadSelect2 = '0;
        WriteSelect = '0;
        Extended    = '0;
        illegal     = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            busy     = (state != FETCH);
            Extended = ext;
            case (cls)
                CL_R, CL_D_LD: begin
                    ReadSelect1 = REG_AW'(ir[9:5]);
                    ReadSelect2 = REG_AW'(ir[20:16]);
                    WriteSelect = REG_AW'(ir[4:0]);
                end
                CL_D_ST: begin
                    ReadSelect1 = REG_AW'(ir[9:5]);
                    ReadSelect2 = REG_AW'(ir[4:0]);
                    WriteSelect = REG_AW'(ir[4:0]);
                end
                CL_CBZ, CL_CBNZ: ReadSelect2 = REG_AW'(ir[4:0]);
                CL_IW: begin
                    ReadSelect1 = REG_AW'(ir[4:0]);
                    WriteSelect = REG_AW'(ir[4:0]);
                end
                default: ;
            endcase
            // alu_op/alusrc_mux stay valid from EXEC through MEM/WB for an unlatched ALU result.
            case (state)
                FETCH: begin
                    instr_ready = 1'b1;
                    pc_write    = instr_valid;
                end
                DECODE: illegal = (cls == CL_ILL);
                EXEC: begin
                    alu_op     = ALU_OP_W'(alu_code_w);
                    alusrc_mux = uses_imm;
                    pc_write   = take_branch;
                    pc_src     = take_branch;
                end
                MEM: begin
                    alu_op     = ALU_OP_W'(alu_code_w);
                    alusrc_mux = uses_imm;
                    mem_req    = !mem_to;
                    memread    = !mem_to && is_ld;
                    memwrite   = !mem_to && is_st;
                    illegal    = mem_to;
                end
                WB: begin
                    alu_op     = ALU_OP_W'(alu_code_w);
                    alusrc_mux = uses_imm;
                    regwrite   = 1'b1;
                    mem2reg    = is_ld;
                end
                default: ;
            endcase
        end
    end

endmodule
